// File: rtl/simm_arb_pkg.sv
// Shared types and defaults for the two-master SIMM controller arbiter.
package simm_arb_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_CPU = 2'd1;
  localparam logic [1:0] ST_GRANT_DMA = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    GRANT_CPU = ST_GRANT_CPU,
    GRANT_DMA = ST_GRANT_DMA,
    RELEASE   = ST_RELEASE
  } arb_state_e;

  localparam logic ADDR_SEL_CPU = 1'b0;
  localparam logic ADDR_SEL_DMA = 1'b1;

  localparam int unsigned DEFAULT_DMA_MAX_WAIT   = 16;
  localparam int unsigned DEFAULT_RELEASE_CYCLES = 3;

  typedef struct packed {
    logic       cs;
    logic       read;
    logic       write;
    logic       bank_addr;
    logic [3:0] byte_selects;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = mem_req_t'(8'h00);

endpackage

// File: rtl/simm_arb_starve_counter.sv
// 8-bit saturating count of cycles the DMA has waited; clear wins over increment.
module simm_arb_starve_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] threshold,
  output logic       starved,
  output logic [7:0] count
);

  logic [7:0] count_r;

  // Wait counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != 8'hff)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign starved = (count_r >= threshold);

endmodule

// File: rtl/simm_arbiter.sv
// Arbitrates the SIMM controller between CPU (fixed priority) and DMA, with a
// starvation override and an enforced idle gap between grants.
module simm_arbiter
  import simm_arb_pkg::*;
#(
  parameter int unsigned DMA_MAX_WAIT   = DEFAULT_DMA_MAX_WAIT,
  parameter int unsigned RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_cs,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic       cpu_bank_addr,
  input  logic [3:0] cpu_byte_selects,
  output logic       cpu_waitstate,
  input  logic       dma_cs,
  input  logic       dma_read,
  input  logic       dma_write,
  input  logic       dma_bank_addr,
  input  logic [3:0] dma_byte_selects,
  output logic       dma_waitstate,
  output logic       mem_cs,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_bank_addr,
  output logic [3:0] mem_byte_selects,
  input  logic       mem_waitstate,
  output logic       addr_select
);

  localparam logic [7:0] THRESHOLD = 8'(DMA_MAX_WAIT);
  localparam logic [1:0] REL_LAST  = 2'(RELEASE_CYCLES - 1);

  arb_state_e state_r;
  arb_state_e state_s;
  logic [1:0] rel_cnt_r;
  logic       addr_select_r;
  logic       starved_s;
  logic       starve_inc_s;
  logic       starve_clr_s;
  logic [7:0] starve_cnt;
  mem_req_t   mem_req_s;

  assign starve_inc_s = dma_cs && (state_r != GRANT_DMA);
  assign starve_clr_s = (state_s == GRANT_DMA) && (state_r != GRANT_DMA);

  simm_arb_starve_counter u_starve (
    .clock     (clock),
    .reset     (reset),
    .inc       (starve_inc_s),
    .clr       (starve_clr_s),
    .threshold (THRESHOLD),
    .starved   (starved_s),
    .count     (starve_cnt)
  );

  // Next-state decision
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dma_cs && starved_s) begin
          state_s = GRANT_DMA;
        end else if (cpu_cs) begin
          state_s = GRANT_CPU;
        end else if (dma_cs) begin
          state_s = GRANT_DMA;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_CPU: begin
        if (!cpu_cs) state_s = RELEASE;
        else         state_s = GRANT_CPU;
      end
      GRANT_DMA: begin
        if (!dma_cs) state_s = RELEASE;
        else         state_s = GRANT_DMA;
      end
      RELEASE: begin
        // A controller still reporting waitstate=0 (trailing or aborted access) keeps us here
        if ((rel_cnt_r == REL_LAST) && mem_waitstate) state_s = IDLE;
        else                                          state_s = RELEASE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Release gap counter: held at zero outside RELEASE so entry always starts from zero
  always_ff @(posedge clock) begin
    if (reset) begin
      rel_cnt_r <= 2'd0;
    end else if (state_r != RELEASE) begin
      rel_cnt_r <= 2'd0;
    end else if (rel_cnt_r != REL_LAST) begin
      rel_cnt_r <= rel_cnt_r + 2'd1;
    end else begin
      rel_cnt_r <= rel_cnt_r;
    end
  end

  // Upstream address mux select, latched only when a grant is issued
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_select_r <= ADDR_SEL_CPU;
    end else if ((state_r == IDLE) && (state_s == GRANT_DMA)) begin
      addr_select_r <= ADDR_SEL_DMA;
    end else if ((state_r == IDLE) && (state_s == GRANT_CPU)) begin
      addr_select_r <= ADDR_SEL_CPU;
    end else begin
      addr_select_r <= addr_select_r;
    end
  end

  assign addr_select = addr_select_r;

  // Controller-side steering and waitstate return
  always_comb begin
    mem_req_s     = MEM_REQ_IDLE;
    cpu_waitstate = 1'b1;
    dma_waitstate = 1'b1;
    case (state_r)
      GRANT_CPU: begin
        mem_req_s     = '{cpu_cs, cpu_read, cpu_write, cpu_bank_addr, cpu_byte_selects};
        cpu_waitstate = mem_waitstate;
      end
      GRANT_DMA: begin
        mem_req_s     = '{dma_cs, dma_read, dma_write, dma_bank_addr, dma_byte_selects};
        dma_waitstate = mem_waitstate;
      end
      default: begin
        mem_req_s = MEM_REQ_IDLE;
      end
    endcase
  end

  assign mem_cs           = mem_req_s.cs;
  assign mem_read         = mem_req_s.read;
  assign mem_write        = mem_req_s.write;
  assign mem_bank_addr    = mem_req_s.bank_addr;
  assign mem_byte_selects = mem_req_s.byte_selects;

endmodule

// File: tb/tb_simm_arbiter.sv
// Directed scoreboard bench for simm_arbiter: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_simm_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_cs, cpu_read, cpu_write, cpu_bank_addr;
  logic [3:0] cpu_byte_selects;
  logic       cpu_waitstate;
  logic       dma_cs, dma_read, dma_write, dma_bank_addr;
  logic [3:0] dma_byte_selects;
  logic       dma_waitstate;
  logic       mem_cs, mem_read, mem_write, mem_bank_addr;
  logic [3:0] mem_byte_selects;
  logic       mem_waitstate;
  logic       addr_select;

  simm_arbiter #(.DMA_MAX_WAIT(16), .RELEASE_CYCLES(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_cs           (cpu_cs),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_bank_addr    (cpu_bank_addr),
    .cpu_byte_selects (cpu_byte_selects),
    .cpu_waitstate    (cpu_waitstate),
    .dma_cs           (dma_cs),
    .dma_read         (dma_read),
    .dma_write        (dma_write),
    .dma_bank_addr    (dma_bank_addr),
    .dma_byte_selects (dma_byte_selects),
    .dma_waitstate    (dma_waitstate),
    .mem_cs           (mem_cs),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_bank_addr    (mem_bank_addr),
    .mem_byte_selects (mem_byte_selects),
    .mem_waitstate    (mem_waitstate),
    .addr_select      (addr_select)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // {mem_cs, mem_read, mem_write, mem_bank_addr, mem_byte_selects, cpu_ws, dma_ws, addr_select}
  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] exp;
    int          es;
  } sb_ent_t;

  sb_ent_t sb[$];
  sb_ent_t ent;
  int checks = 0;
  int errors = 0;

  function automatic logic [10:0] e_idle(input logic asel);
    return {4'b0000, 4'b0000, 1'b1, 1'b1, asel};
  endfunction

  function automatic logic [10:0] e_cpu();
    return {cpu_cs, cpu_read, cpu_write, cpu_bank_addr, cpu_byte_selects, mem_waitstate, 1'b1, 1'b0};
  endfunction

  function automatic logic [10:0] e_dma();
    return {dma_cs, dma_read, dma_write, dma_bank_addr, dma_byte_selects, 1'b1, mem_waitstate, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [10:0] e, input int es);
    sb_ent_t x;
    x.cyc = cyc;
    x.tag = tag;
    x.exp = e;
    x.es  = es;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic cs, input logic rd, input logic wr, input logic ba, input logic [3:0] bs);
    cpu_cs = cs; cpu_read = rd; cpu_write = wr; cpu_bank_addr = ba; cpu_byte_selects = bs;
  endtask

  task automatic set_dma(input logic cs, input logic rd, input logic wr, input logic ba, input logic [3:0] bs);
    dma_cs = cs; dma_read = rd; dma_write = wr; dma_bank_addr = ba; dma_byte_selects = bs;
  endtask

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clock) begin
    logic [10:0] act;
    act = {mem_cs, mem_read, mem_write, mem_bank_addr, mem_byte_selects,
           cpu_waitstate, dma_waitstate, addr_select};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ent = sb.pop_front();
      checks = checks + 1;
      if (ent.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL %s stale entry: queued cycle %0d, now %0d", ent.tag, ent.cyc, cyc);
      end else if (act !== ent.exp) begin
        errors = errors + 1;
        $display("FAIL %s cycle %0d outputs got %b want %b", ent.tag, cyc, act, ent.exp);
      end
      if (ent.es >= 0) begin
        checks = checks + 1;
        if (int'(dut.starve_cnt) != ent.es) begin
          errors = errors + 1;
          $display("FAIL %s cycle %0d starve_cnt got %0d want %0d", ent.tag, cyc, dut.starve_cnt, ent.es);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_waitstate = 1'b1;
    set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    set_dma(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_state", e_idle(1'b0), 0); step();

    // Single CPU read, then a queued CPU write across the release gap
    set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'hf);
    chk("t1_idle", e_idle(1'b0), 0); step();
    chk("t1_grant", e_cpu(), -1); step();
    chk("t1_wait", e_cpu(), -1); step();
    mem_waitstate = 1'b0;
    chk("t1_done", e_cpu(), -1); step();
    set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 4'hf); mem_waitstate = 1'b1;
    chk("t1_drop", e_cpu(), -1); step();
    set_cpu(1'b1, 1'b0, 1'b1, 1'b1, 4'h3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_release", e_idle(1'b0), -1); step();
    end
    chk("t1_idle2", e_idle(1'b0), -1); step();
    chk("t1_wr_grant", e_cpu(), -1); step();
    mem_waitstate = 1'b0;
    chk("t1_wr_done", e_cpu(), -1); step();
    set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("t1_wr_drop", e_cpu(), -1); step();
    chk("t1_trail_mask", e_idle(1'b0), -1); step();
    mem_waitstate = 1'b1;
    chk("t1_rel2", e_idle(1'b0), -1); step();
    chk("t1_rel2", e_idle(1'b0), -1); step();

    // Simultaneous requests: CPU first, then DMA write with byte selects 0110
    set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'hf);
    set_dma(1'b1, 1'b0, 1'b1, 1'b1, 4'h6);
    chk("t2_idle", e_idle(1'b0), 0); step();
    chk("t2_cpu_first", e_cpu(), 1); step();
    mem_waitstate = 1'b0;
    chk("t2_cpu_done", e_cpu(), 2); step();
    set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 4'h0); mem_waitstate = 1'b1;
    chk("t2_cpu_drop", e_cpu(), 3); step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_release", e_idle(1'b0), 4 + i); step();
    end
    chk("t2_idle_dma", e_idle(1'b0), 7); step();
    chk("t2_dma_grant", e_dma(), 0); step();
    mem_waitstate = 1'b0;
    chk("t2_dma_done", e_dma(), 0); step();
    set_dma(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    chk("t2_dma_drop", e_dma(), 0); step();
    chk("t2_bs_release", e_idle(1'b1), 0); step();
    mem_waitstate = 1'b1;
    chk("t2_rel", e_idle(1'b1), 0); step();
    chk("t2_rel", e_idle(1'b1), 0); step();
    set_dma(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Starvation: back-to-back CPU reads while DMA waits
    set_dma(1'b1, 1'b1, 1'b0, 1'b0, 4'hf);
    for (int t = 0; t < 3; t++) begin
      set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'hf); mem_waitstate = 1'b1;
      chk("t3_idle", e_idle((t == 0) ? 1'b1 : 1'b0), 6 * t); step();
      mem_waitstate = 1'b0;
      chk("t3_cpu", e_cpu(), 6 * t + 1); step();
      set_cpu(1'b0, 1'b1, 1'b0, 1'b0, 4'hf); mem_waitstate = 1'b1;
      chk("t3_cpu_drop", e_cpu(), 6 * t + 2); step();
      set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'hf);
      for (int i = 0; i < 3; i++) begin
        chk("t3_rel", e_idle(1'b0), 6 * t + 3 + i); step();
      end
    end
    chk("t3_starved_idle", e_idle(1'b0), 18); step();
    chk("t3_dma_grant", e_dma(), 0); step();
    mem_waitstate = 1'b0;
    chk("t3_dma_done", e_dma(), 0); step();
    set_dma(1'b0, 1'b1, 1'b0, 1'b0, 4'hf); mem_waitstate = 1'b1;
    chk("t3_dma_drop", e_dma(), 0); step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_rel_dma", e_idle(1'b1), 0); step();
    end

    // CPU abort in first access cycle; controller keeps waitstate=0 for a while
    set_dma(1'b1, 1'b0, 1'b1, 1'b1, 4'h6);
    chk("t4_idle", e_idle(1'b1), 0); step();
    chk("t4_grant", e_cpu(), 1); step();
    set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("t4_abort", e_cpu(), 2); step();
    mem_waitstate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_rel_hold", e_idle(1'b0), 3 + i); step();
    end
    mem_waitstate = 1'b1;
    chk("t4_rel_end", e_idle(1'b0), 7); step();
    chk("t4_idle_dma", e_idle(1'b0), 8); step();
    chk("t4_dma_noleak", e_dma(), 0); step();

    // Reset while DMA is granted
    reset = 1'b1;
    chk("t5_pre_reset", e_dma(), 0); step();
    reset = 1'b0;
    chk("t5_after_reset", e_idle(1'b0), 0); step();
    set_dma(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (6) step();

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simm_arbiter.md
# simm_arbiter

Shares the single SIMM controller between two bus masters: the CPU and the DMA engine. Sits between the masters and the controller's `cs`/`read`/`write`/`bank_addr`/`byte_selects` inputs, steers the upstream address mux in front of the SIMM row/column mux, and routes the controller's `waitstate` back to the granted master only. The CPU has fixed priority, with a starvation counter that guarantees DMA service.

## Interface
- `DMA_MAX_WAIT`, 16: cycles DMA may wait while the CPU wins before DMA is forced to win (1..255).
- `RELEASE_CYCLES`, 3: minimum cycles the controller interface is held idle between grants (2..3).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_cs`, `cpu_read`, `cpu_write`, `cpu_bank_addr`  in  1 each  CPU request.
- `cpu_byte_selects`  in  4  CPU byte enables.
- `cpu_waitstate`  out  1  0 means the CPU access has completed.
- `dma_cs`, `dma_read`, `dma_write`, `dma_bank_addr`  in  1 each  DMA request.
- `dma_byte_selects`  in  4  DMA byte enables.
- `dma_waitstate`  out  1  0 means the DMA access has completed.
- `mem_cs`, `mem_read`, `mem_write`, `mem_bank_addr`  out  1 each  to the controller.
- `mem_byte_selects`  out  4  to the controller.
- `mem_waitstate`  in  1  from the controller.
- `addr_select`  out  1  0 selects the CPU address, 1 selects the DMA address, for the upstream 32-bit mux.

## Operation
- States:
  - IDLE: no grant.
  - GRANT_CPU / GRANT_DMA: one master is granted.
  - RELEASE: the controller interface is forced idle between grants.
- IDLE:
  - If `dma_cs` is set and `starve_cnt` ≥ `DMA_MAX_WAIT`, go to GRANT_DMA.
  - Else if `cpu_cs`, go to GRANT_CPU.
  - Else if `dma_cs`, go to GRANT_DMA.
  - Else stay in IDLE.
- `addr_select` is registered. It updates on the IDLE→GRANT transition and holds through GRANT and RELEASE.
- In GRANT_x:
  - `mem_cs` = x_cs.
  - `mem_read`, `mem_write`, `mem_bank_addr` and `mem_byte_selects` pass the granted master's signals through combinationally.
  - x_waitstate = `mem_waitstate`.
  - The other master's waitstate is 1.
- In GRANT_x, when `x_cs` is sampled low (normal completion or abort), go to RELEASE.
- In IDLE and RELEASE:
  - `mem_cs`, `mem_read` and `mem_write` are 0.
  - `mem_byte_selects` is 0000.
  - Both master waitstates are 1.
- RELEASE:
  - A 2-bit counter is cleared on entry.
  - Exit to IDLE when the counter equals `RELEASE_CYCLES`-1 and `mem_waitstate` is 1.
  - Otherwise increment, saturating.
  - This masks the controller's trailing waitstate=0 cycle, including aborts issued during the controller's first access cycle.
- `starve_cnt` (8-bit, saturating at 255):
  - Increments every cycle that `dma_cs` is 1 and the state is not GRANT_DMA.
  - Clears on entry to GRANT_DMA.
  - Holds its value when `dma_cs` is 0.
- Refresh is owned by the controller. The arbiter only sees `mem_waitstate` stay 1 longer.

## Timing
- Reset values: state IDLE, `addr_select` 0, `starve_cnt` 0, all `mem_*` outputs 0, `cpu_waitstate` = `dma_waitstate` = 1.
- Grant latency: a request sampled in IDLE at edge N produces `mem_cs` high in the cycle after edge N.
- Back-to-back turnaround: with `RELEASE_CYCLES`=3, `mem_cs` falls in the cycle after `x_cs` is sampled low. The next grant's `mem_cs` rises no earlier than 4 cycles after that.
- Simultaneous CPU and DMA requests in IDLE: the CPU wins unless the starvation threshold has been reached.
- Reset mid-grant: all outputs go to their reset values in the cycle after the reset edge. The controller is reset by the same signal.
- Masters must hold `cs`/`read`/`write`/`bank_addr`/`byte_selects` stable until they see their waitstate at 0, then drop `cs`.

## Structure
- Package `simm_arb_pkg`:
  - state encoding localparams (IDLE, GRANT_CPU, GRANT_DMA, RELEASE);
  - `ADDR_SEL_CPU` = 0 and `ADDR_SEL_DMA` = 1;
  - default `DMA_MAX_WAIT` and `RELEASE_CYCLES`.
- Sub-module `simm_arb_starve_counter`: the 8-bit saturating counter, with inputs inc, clr and threshold, and output `starved`.
- The top level holds the FSM, the release counter and the output steering.

## Test plan
- Single CPU read: `cpu_cs`=`cpu_read`=1 with bank 0. Expect `mem_cs` high in the cycle after IDLE samples it, `addr_select`=0, `dma_waitstate` stuck at 1, and `cpu_waitstate` following the model controller. After `cpu_cs` drops, expect RELEASE for ≥3 cycles.
- Simultaneous requests from reset: expect CPU granted first and DMA granted at the first IDLE after the CPU's RELEASE, with `addr_select` going to 1.
- Starvation with `DMA_MAX_WAIT`=16: CPU requests back-to-back continuously while DMA holds `dma_cs`. Expect a DMA grant at the first IDLE after `starve_cnt` reaches 16, even though `cpu_cs`=1, and `starve_cnt` reading 0 after the grant.
- Abort: `cpu_cs` drops one cycle after the grant, before waitstate=0. Expect `cpu_waitstate` to stay 1 throughout, RELEASE to extend until `mem_waitstate`=1, and no waitstate=0 to leak to the next DMA grant.
- DMA write with `dma_byte_selects`=0110: expect `mem_byte_selects`=0110 and `mem_write`=1 while granted, and `mem_byte_selects`=0000 in RELEASE.
- Reset asserted during GRANT_DMA: expect IDLE, `addr_select`=0, both waitstates 1 and `starve_cnt`=0 in the cycle after the reset edge.
